// File: rtl/decode_stage.sv
// Instruction-decode stage: field extraction, register-file reads with
// write-through bypass, and a one-entry pipeline register feeding execute.
module decode_stage #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_FPU   = 6'h11,
   parameter logic [5:0] OP_J     = 6'h02,
   parameter logic [5:0] OP_JAL   = 6'h03,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_BNE   = 6'h05,
   parameter logic [5:0] OP_LW_S  = 6'h31,
   parameter logic [5:0] OP_SW_S  = 6'h39,
   parameter logic [5:0] FUNC_JR  = 6'h08
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instr,
   output logic        id_ready,
   input  logic        ex_busy,
   input  logic        flush,
   input  logic [1:0]  wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_d,
   output logic [31:0] pc,
   output logic [1:0]  op_type,
   output logic [5:0]  instr,
   output logic [31:0] de_s,
   output logic [31:0] de_t,
   output logic [5:0]  de_rs,
   output logic [5:0]  de_rt,
   output logic [4:0]  de_rd,
   output logic [1:0]  de_rw,
   output logic [31:0] imm,
   output logic        branch,
   output logic        jump,
   output logic        is_jr,
   output logic        start
);

   // Handshake: a fetch word transfers on a clock edge where if_valid and
   // id_ready are both high; id_ready depends only on ex_busy (and reset).
   logic [31:0] int_rf_q [32];
   logic [31:0] fp_rf_q  [32];

   always_ff @(posedge clk) begin
      if (wb_we[0] && (wb_rd != 5'd0)) int_rf_q[wb_rd] <= wb_d;
      if (wb_we[1])                    fp_rf_q[wb_rd]  <= wb_d;
   end

   // Read value of {bank, idx} as seen after this cycle's writeback lands.
   function automatic logic [31:0] fwd(input logic bank, input logic [4:0] idx,
                                       input logic [31:0] stored, input logic [1:0] we,
                                       input logic [4:0] rd, input logic [31:0] d);
      logic [31:0] v;
      v = stored;
      if (!bank && (idx == 5'd0)) v = '0;
      else if (we[bank] && (rd == idx)) v = d;
      return v;
   endfunction

   logic [5:0]  opcode, funct;
   logic [4:0]  f_rs, f_rt;
   logic        is_r, is_fpu, is_j, is_jal, is_br, is_jr_n;
   logic        rs_fp, rt_fp, wr_fp, wr_en;
   logic [1:0]  op_type_n, de_rw_n;
   logic [5:0]  instr_n;
   logic [4:0]  de_rd_n;
   logic [31:0] imm_n, rs_raw, rt_raw, de_s_n, de_t_n;

   always_comb begin
      opcode    = if_instr[31:26];
      funct     = if_instr[5:0];
      f_rs      = if_instr[25:21];
      f_rt      = if_instr[20:16];
      is_r      = (opcode == OP_RTYPE);
      is_fpu    = (opcode == OP_FPU);
      is_j      = (opcode == OP_J);
      is_jal    = (opcode == OP_JAL);
      is_br     = (opcode == OP_BEQ) || (opcode == OP_BNE);
      is_jr_n   = is_r && (funct == FUNC_JR);
      rs_fp     = is_fpu;
      rt_fp     = is_fpu || (opcode == OP_LW_S) || (opcode == OP_SW_S);
      wr_fp     = is_fpu || (opcode == OP_LW_S);
      // Writers: R-type except jr, FPU, float load, jal, I-type ALU 08-0F, loads 20-27.
      wr_en     = (is_r && !is_jr_n) || wr_fp || is_jal ||
                  (opcode[5:3] == 3'b001) || (opcode[5:3] == 3'b100);
      op_type_n = is_r ? 2'b01 : (is_fpu ? 2'b10 : 2'b00);
      instr_n   = (is_r || is_fpu) ? funct : opcode;
      imm_n     = (is_j || is_jal) ? {6'b0, if_instr[25:0]}
                                   : {{16{if_instr[15]}}, if_instr[15:0]};
      if (is_jal)               de_rd_n = 5'd31;
      else if (is_r || is_fpu)  de_rd_n = if_instr[15:11];
      else                      de_rd_n = f_rt;
      de_rw_n   = !wr_en ? 2'b00 : (wr_fp ? 2'b10 : 2'b01);
      rs_raw    = rs_fp ? fp_rf_q[f_rs] : int_rf_q[f_rs];
      rt_raw    = rt_fp ? fp_rf_q[f_rt] : int_rf_q[f_rt];
      de_s_n    = is_jal ? (if_pc + 32'd4) : fwd(rs_fp, f_rs, rs_raw, wb_we, wb_rd, wb_d);
      de_t_n    = fwd(rt_fp, f_rt, rt_raw, wb_we, wb_rd, wb_d);
   end

   logic [31:0] pc_q, pc_d, de_s_q, de_s_d, de_t_q, de_t_d, imm_q, imm_d;
   logic [1:0]  op_type_q, op_type_d, de_rw_q, de_rw_d;
   logic [5:0]  instr_q, instr_d, de_rs_q, de_rs_d, de_rt_q, de_rt_d;
   logic [4:0]  de_rd_q, de_rd_d;
   logic        branch_q, branch_d, jump_q, jump_d, is_jr_q, is_jr_d;
   logic        start_q, start_d, link_q, link_d;

   always_comb begin
      pc_d      = pc_q;
      op_type_d = op_type_q;
      instr_d   = instr_q;
      de_rs_d   = de_rs_q;
      de_rt_d   = de_rt_q;
      de_rd_d   = de_rd_q;
      de_rw_d   = de_rw_q;
      imm_d     = imm_q;
      branch_d  = branch_q;
      jump_d    = jump_q;
      is_jr_d   = is_jr_q;
      link_d    = link_q;
      start_d   = 1'b0;
      // Held operands track writebacks so execute never sees a stale value.
      de_s_d    = link_q ? de_s_q : fwd(de_rs_q[5], de_rs_q[4:0], de_s_q, wb_we, wb_rd, wb_d);
      de_t_d    = fwd(de_rt_q[5], de_rt_q[4:0], de_t_q, wb_we, wb_rd, wb_d);
      if (flush) begin
         op_type_d = 2'b00;
         instr_d   = 6'd0;
         de_rw_d   = 2'b00;
         branch_d  = 1'b0;
         jump_d    = 1'b0;
         is_jr_d   = 1'b0;
      end else if (!ex_busy && if_valid) begin
         pc_d      = if_pc;
         op_type_d = op_type_n;
         instr_d   = instr_n;
         de_rs_d   = {rs_fp, f_rs};
         de_rt_d   = {rt_fp, f_rt};
         de_rd_d   = de_rd_n;
         de_rw_d   = de_rw_n;
         imm_d     = imm_n;
         branch_d  = is_br;
         jump_d    = is_j || is_jal;
         is_jr_d   = is_jr_n;
         link_d    = is_jal;
         de_s_d    = de_s_n;
         de_t_d    = de_t_n;
         start_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= '0;
         op_type_q <= '0;
         instr_q   <= '0;
         de_s_q    <= '0;
         de_t_q    <= '0;
         de_rs_q   <= '0;
         de_rt_q   <= '0;
         de_rd_q   <= '0;
         de_rw_q   <= '0;
         imm_q     <= '0;
         branch_q  <= 1'b0;
         jump_q    <= 1'b0;
         is_jr_q   <= 1'b0;
         link_q    <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         op_type_q <= op_type_d;
         instr_q   <= instr_d;
         de_s_q    <= de_s_d;
         de_t_q    <= de_t_d;
         de_rs_q   <= de_rs_d;
         de_rt_q   <= de_rt_d;
         de_rd_q   <= de_rd_d;
         de_rw_q   <= de_rw_d;
         imm_q     <= imm_d;
         branch_q  <= branch_d;
         jump_q    <= jump_d;
         is_jr_q   <= is_jr_d;
         link_q    <= link_d;
         start_q   <= start_d;
      end
   end

   assign id_ready = !ex_busy && !rst;
   assign pc       = pc_q;
   assign op_type  = op_type_q;
   assign instr    = instr_q;
   assign de_s     = de_s_q;
   assign de_t     = de_t_q;
   assign de_rs    = de_rs_q;
   assign de_rt    = de_rt_q;
   assign de_rd    = de_rd_q;
   assign de_rw    = de_rw_q;
   assign imm      = imm_q;
   assign branch   = branch_q;
   assign jump     = jump_q;
   assign is_jr    = is_jr_q;
   assign start    = start_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan steps followed by random traffic,
// checked against a field-level reference model and a pc scoreboard.
module tb_decode_stage;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_FPU = 6'h11, OP_J = 6'h02, OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_LW_S = 6'h31, OP_SW_S = 6'h39;
   localparam logic [5:0] FUNC_JR = 6'h08;

   logic        clk, rst, if_valid, ex_busy, flush;
   logic [31:0] if_pc, if_instr, wb_d;
   logic [1:0]  wb_we;
   logic [4:0]  wb_rd;
   logic        id_ready;
   logic [31:0] pc, de_s, de_t, imm;
   logic [1:0]  op_type, de_rw;
   logic [5:0]  instr, de_rs, de_rt;
   logic [4:0]  de_rd;
   logic        branch, jump, is_jr, start;

   decode_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .id_ready(id_ready), .ex_busy(ex_busy), .flush(flush),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_d(wb_d),
      .pc(pc), .op_type(op_type), .instr(instr), .de_s(de_s), .de_t(de_t),
      .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd), .de_rw(de_rw), .imm(imm),
      .branch(branch), .jump(jump), .is_jr(is_jr), .start(start)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [1:0]  op_type;
      logic [5:0]  instr;
      logic [5:0]  rs;
      logic [5:0]  rt;
      logic [4:0]  rd;
      logic [1:0]  rw;
      logic [31:0] imm;
      logic        branch, jump, is_jr, start, link;
   } bundle_t;

   int          checks = 0;
   int          errors = 0;
   bundle_t     exp_b;
   logic [31:0] m_int [32];
   logic [31:0] m_fp  [32];
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] rf_val(input logic [5:0] r);
      if (r[5]) return m_fp[r[4:0]];
      if (r[4:0] == 5'd0) return 32'd0;
      return m_int[r[4:0]];
   endfunction

   // Reference decode: what execute should see for word w fetched at p.
   function automatic bundle_t decode_ref(input logic [31:0] w, input logic [31:0] p);
      bundle_t     e;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic        fp_s, fp_t;
      opc = w[31:26];
      fn  = w[5:0];
      fp_s = 1'b0;
      fp_t = 1'b0;
      e = '0;
      e.pc = p;
      e.start = 1'b1;
      e.instr = opc;
      e.rd = w[20:16];
      e.imm = {{16{w[15]}}, w[15:0]};
      case (opc)
         OP_RTYPE: begin
            e.op_type = 2'b01; e.instr = fn; e.rd = w[15:11];
            e.is_jr = (fn == FUNC_JR);
            e.rw = (fn == FUNC_JR) ? 2'b00 : 2'b01;
         end
         OP_FPU: begin
            e.op_type = 2'b10; e.instr = fn; e.rd = w[15:11];
            fp_s = 1'b1; fp_t = 1'b1; e.rw = 2'b10;
         end
         OP_J:    begin e.jump = 1'b1; e.imm = {6'b0, w[25:0]}; end
         OP_JAL:  begin e.jump = 1'b1; e.link = 1'b1; e.imm = {6'b0, w[25:0]}; e.rd = 5'd31; e.rw = 2'b01; end
         OP_BEQ, OP_BNE: e.branch = 1'b1;
         OP_LW_S: begin fp_t = 1'b1; e.rw = 2'b10; end
         OP_SW_S: fp_t = 1'b1;
         default: e.rw = (opc inside {[6'h08:6'h0f], [6'h20:6'h27]}) ? 2'b01 : 2'b00;
      endcase
      e.rs = {fp_s, w[25:21]};
      e.rt = {fp_t, w[20:16]};
      return e;
   endfunction

   task automatic check_out();
      chk("start", start, exp_b.start);
      if (start === 1'b1) begin
         chk("sb_depth", exp_q.size(), 1);
         if (exp_q.size() > 0) chk("sb_pc", pc, exp_q.pop_front());
      end
      chk("pc", pc, exp_b.pc);
      chk("op_type", op_type, exp_b.op_type);
      chk("instr", instr, exp_b.instr);
      chk("de_rs", de_rs, exp_b.rs);
      chk("de_rt", de_rt, exp_b.rt);
      chk("de_rd", de_rd, exp_b.rd);
      chk("de_rw", de_rw, exp_b.rw);
      chk("imm", imm, exp_b.imm);
      chk("branch", branch, exp_b.branch);
      chk("jump", jump, exp_b.jump);
      chk("is_jr", is_jr, exp_b.is_jr);
      chk("de_s", de_s, exp_b.link ? exp_b.pc + 32'd4 : rf_val(exp_b.rs));
      chk("de_t", de_t, rf_val(exp_b.rt));
   endtask

   // driver: one clock of stimulus, model update, then output check
   task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                       input logic b, input logic f, input logic [1:0] we,
                       input logic [4:0] rd, input logic [31:0] d);
      if_valid = v; if_instr = w; if_pc = p; ex_busy = b; flush = f;
      wb_we = we; wb_rd = rd; wb_d = d;
      #1;
      chk("id_ready", id_ready, !b);
      if (we[0] && rd != 5'd0) m_int[rd] = d;
      if (we[1]) m_fp[rd] = d;
      if (f) begin
         exp_b.start = 1'b0; exp_b.op_type = 2'b00; exp_b.instr = 6'd0; exp_b.rw = 2'b00;
         exp_b.branch = 1'b0; exp_b.jump = 1'b0; exp_b.is_jr = 1'b0;
      end else if (!b && v) begin
         exp_b = decode_ref(w, p);
         exp_q.push_back(p);
      end else begin
         exp_b.start = 1'b0;
      end
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {op, rs, rt, rd, 5'd3, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] k);
      return {op, rs, rt, k};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 12))
         0: w[31:26] = OP_RTYPE;
         1: begin w[31:26] = OP_RTYPE; w[5:0] = FUNC_JR; end
         2: w[31:26] = OP_FPU;
         3: w[31:26] = OP_J;
         4: w[31:26] = OP_JAL;
         5: w[31:26] = OP_BEQ;
         6: w[31:26] = OP_BNE;
         7: w[31:26] = OP_LW_S;
         8: w[31:26] = OP_SW_S;
         9: w[31:26] = 6'h08 + 6'($urandom_range(0, 7));
         10: w[31:26] = 6'h23;
         11: w[31:26] = 6'h2b;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      logic        v, b, f;
      logic [1:0]  we;
      logic [4:0]  rd;
      exp_b = '0;
      m_int[0] = 32'd0;
      rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; ex_busy = 1'b0;
      flush = 1'b0; wb_we = '0; wb_rd = '0; wb_d = '0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("rst_id_ready", id_ready, 0);
         check_out();
      end
      rst = 1'b0;

      for (int i = 1; i < 32; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 5'(i), $urandom());
      for (int i = 0; i < 32; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 2'b10, 5'(i), $urandom());

      // add $3,$1,$2 with r1=5, r2=7
      step(1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 5'd1, 32'd5);
      step(1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 5'd2, 32'd7);
      step(1'b1, enc_r(OP_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20), 32'h100, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
      chk("tp_add_optype", op_type, 2'b01);
      chk("tp_add_instr", instr, 6'h20);
      chk("tp_add_s", de_s, 32'd5);
      chk("tp_add_t", de_t, 32'd7);
      chk("tp_add_rs", de_rs, 6'h01);
      chk("tp_add_rd", de_rd, 5'd3);
      chk("tp_add_rw", de_rw, 2'b01);
      idle(1);
      chk("tp_add_one_pulse", start, 1'b0);

      // same-cycle writeback bypass
      step(1'b1, enc_i(6'h08, 5'd4, 5'd5, 16'h1), 32'h104, 1'b0, 1'b0, 2'b01, 5'd4, 32'hDEAD);
      chk("tp_bypass_s", de_s, 32'hDEAD);

      // r0 stays zero, f0 is ordinary
      step(1'b0, 0, 0, 1'b0, 1'b0, 2'b01, 5'd0, 32'd9);
      step(1'b1, enc_i(6'h08, 5'd0, 5'd5, 16'h3), 32'h108, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
      chk("tp_r0_s", de_s, 32'd0);
      step(1'b1, enc_r(OP_FPU, 5'd0, 5'd1, 5'd2, 6'h00), 32'h10c, 1'b0, 1'b0, 2'b10, 5'd0, 32'd9);
      chk("tp_f0_s", de_s, 32'd9);
      chk("tp_f0_rs", de_rs, 6'h20);

      // jal
      step(1'b1, {OP_JAL, 26'h000100}, 32'h40, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
      chk("tp_jal_jump", jump, 1'b1);
      chk("tp_jal_imm", imm, 32'h100);
      chk("tp_jal_rd", de_rd, 5'd31);
      chk("tp_jal_s", de_s, 32'h44);
      chk("tp_jal_rw", de_rw, 2'b01);

      // stall with writeback to held rs, then release
      step(1'b1, enc_i(6'h08, 5'd6, 5'd7, 16'h2), 32'h200, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
      step(1'b1, enc_i(OP_BEQ, 5'd1, 5'd2, 16'h4), 32'h204, 1'b1, 1'b0, 2'b00, 5'd0, 32'd0);
      step(1'b1, enc_i(OP_BEQ, 5'd1, 5'd2, 16'h4), 32'h204, 1'b1, 1'b0, 2'b01, 5'd6, 32'h1234);
      chk("tp_stall_s", de_s, 32'h1234);
      chk("tp_stall_pc", pc, 32'h200);
      step(1'b1, enc_i(OP_BEQ, 5'd1, 5'd2, 16'h4), 32'h204, 1'b1, 1'b0, 2'b00, 5'd0, 32'd0);
      chk("tp_stall_start", start, 1'b0);
      step(1'b1, enc_i(OP_BEQ, 5'd1, 5'd2, 16'h4), 32'h204, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
      chk("tp_release_start", start, 1'b1);
      chk("tp_release_branch", branch, 1'b1);
      idle(1);

      // flush beats busy and drops the fetch
      step(1'b1, enc_r(OP_RTYPE, 5'd1, 5'd0, 5'd0, FUNC_JR), 32'h300, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
      chk("tp_jr", is_jr, 1'b1);
      step(1'b1, {OP_J, 26'h3}, 32'h304, 1'b1, 1'b1, 2'b00, 5'd0, 32'd0);
      chk("tp_flush_start", start, 1'b0);
      chk("tp_flush_optype", op_type, 2'b00);
      chk("tp_flush_instr", instr, 6'd0);
      chk("tp_flush_flags", {branch, jump, is_jr}, 3'b000);

      // random traffic
      for (int n = 0; n < 500; n++) begin
         v  = ($urandom_range(0, 3) != 0);
         b  = ($urandom_range(0, 4) == 0);
         f  = ($urandom_range(0, 9) == 0);
         we = 2'($urandom_range(0, 3));
         rd = ($urandom_range(0, 2) == 0) ? exp_b.rs[4:0] : 5'($urandom_range(0, 31));
         step(v, rand_instr(), {$urandom_range(0, 32'h3fff_ffff), 2'b00}, b, f, we, rd, $urandom());
      end
      idle(2);
      chk("sb_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode pipeline stage that sits directly upstream of the execute stage.
- Takes fetched instruction words, reads the integer and float register files, and produces the registered operand/control bundle execute consumes: op_type, instr, de_s/de_rs, de_t/de_rt, imm, branch, jump, is_jr, start.
- Owns both 32x32 register files and their writeback port.
- Handles stalls from execute's UART busy and flushes on a redirected pc.

Parameters:
- OP_RTYPE, 6'h00, opcode of integer R-type; op_type=01, instr=funct.
- OP_FPU, 6'h11, opcode of FPU ops; op_type=10, instr=funct.
- OP_J, 6'h02, jump opcode.
- OP_JAL, 6'h03, jump-and-link opcode.
- OP_BEQ, 6'h04, first branch opcode.
- OP_BNE, 6'h05, second branch opcode.
- OP_LW_S, 6'h31, float load opcode.
- OP_SW_S, 6'h39, float store opcode.
- FUNC_JR, 6'h08, R-type funct of jr.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_valid  in  1  fetch presents an instruction
- if_pc  in  32  pc of fetched instruction
- if_instr  in  32  instruction word
- id_ready  out  1  stage accepts if_* this cycle
- ex_busy  in  1  execute stall (uart_state)
- flush  in  1  redirect taken; discard held instruction
- wb_we  in  2  bit0 int-file write, bit1 float-file write
- wb_rd  in  5  writeback register index
- wb_d  in  32  writeback data
- pc  out  32  pc of decoded instruction
- op_type  out  2  00 I/J, 01 integer R, 10 FPU
- instr  out  6  opcode (op_type 00) or funct
- de_s, de_t  out  32  operand values
- de_rs, de_rt  out  6  {bank, index}; bank 1 = float
- de_rd  out  5  destination index
- de_rw  out  2  destination write enables, same encoding as wb_we
- imm  out  32  immediate
- branch, jump, is_jr  out  1  control flags
- start  out  1  one-cycle pulse: new instruction valid to execute

Behaviour:
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm16[15:0], target[25:0].
- imm selection:
  - J/JAL: imm = {6'b0, target}.
  - Otherwise: imm = sign-extended imm16.
  - R-type: imm is still imm16 sign-extended, so execute's h = imm[10:6] is the shamt.
- Banks:
  - op_type 10: rs and rt read the float bank.
  - LW_S/SW_S: rs int, rt float.
  - Everything else: int bank.
- Destination:
  - R-type and FPU: de_rd = rd.
  - I-type: de_rd = rt.
  - JAL: de_rd = 31, and de_s = if_pc + 4.
  - de_rw bank follows the destination bank.
  - de_rw = 0 for stores, branches, J, JR, and the OUT-type ops (opcode not in the write set).
- Control flags:
  - jump = J|JAL.
  - branch = BEQ|BNE.
  - is_jr = op_type 01 and funct == FUNC_JR.
- Register files:
  - Writes happen on posedge when wb_we bit is set.
  - Int r0 always reads 0 and writes to it are ignored; float f0 is an ordinary register.
  - Same-cycle read of the register being written returns wb_d (write-through bypass).
- Pipeline register, one entry:
  - id_ready = !ex_busy.
  - If id_ready && if_valid, the outputs load next cycle and start=1 for exactly that cycle.
  - If id_ready && !if_valid, start=0 and the outputs hold.
  - If ex_busy, all outputs hold and start=0. Held de_s/de_t still update from a writeback to a matching held de_rs/de_rt so stale operands are never presented.
- Flush:
  - Next cycle: start=0; op_type=00, instr=0, flags 0, de_rw=0.
  - A simultaneous if_valid is dropped.
  - Flush has priority over ex_busy.
- Reset: every output 0; id_ready goes to 0 during reset. Register files are not cleared; a testbench must write before reading.
- Latency: one cycle from accepted fetch to start.

Test Plan:
- Reset, then R-type add $3,$1,$2 with r1=5, r2=7 → next cycle op_type=01, instr=6'h20, de_s=5, de_t=7, de_rs=6'h01, de_rd=3, de_rw=01, start=1 for one cycle.
- wb_we=01, wb_rd=4, wb_d=32'hDEAD in the same cycle that an instruction reading rs=4 is accepted → de_s=32'hDEAD.
- Write r0=9, then read rs=0 → de_s=0. Write f0=9 with an FPU add reading f0 → de_s=9, de_rs=6'h20.
- JAL target 26'h000100 at if_pc=32'h40 → jump=1, imm=32'h100, de_rd=31, de_s=32'h44, de_rw=01.
- ex_busy high 3 cycles while if_valid stays high → id_ready=0, outputs frozen, start=0. A writeback to the held rs updates de_s. After release, exactly one start pulse.
- flush together with if_valid and ex_busy → next cycle start=0, op_type=00, instr=0, branch=jump=is_jr=0.
